// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: assembles UART_DEC tokens into "W aaaa dd" / "R aaaa" commands,
// drives the register bus and streams back an ASCII response.
module uart_cmd_ctrl #(
   parameter int unsigned ADDR_DIGITS = 4,
   parameter int unsigned DATA_DIGITS = 2,
   parameter int unsigned TIMEOUT_CYC = 10000000
) (
   input  logic                     CLK_100M,
   input  logic                     SYS_RST_N,
   input  logic                     UART_DEC_DVLD,
   input  logic [2:0]               UART_DEC_STATE,
   input  logic [2:0]               UART_DEC_TEXT,
   input  logic [3:0]               UART_DEC_DATA,
   output logic                     REG_WE,
   output logic                     REG_RE,
   output logic [4*ADDR_DIGITS-1:0] REG_ADDR,
   output logic [4*DATA_DIGITS-1:0] REG_WDATA,
   input  logic [7:0]               REG_RDATA,
   input  logic                     REG_RVLD,
   output logic                     TX_DVLD,
   output logic [7:0]               TX_DATA,
   input  logic                     TX_RDY,
   output logic                     CMD_BUSY,
   output logic                     TOK_DROP
);

   localparam int unsigned AW = 4 * ADDR_DIGITS;
   localparam int unsigned DW = 4 * DATA_DIGITS;
   localparam int unsigned CW = $clog2(ADDR_DIGITS + DATA_DIGITS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [3:0] {
      StIdle, StSep1, StAddr, StData, StExecWr, StExecRd, StFlush, StErrResp, StResp
   } state_e;

   typedef enum logic [2:0] {TokNone, TokW, TokR, TokFail, TokSp, TokEol, TokHex} tok_e;

   state_e          state_q, state_d;
   logic            op_wr_q, op_wr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic [3:0][7:0] resp_q, resp_d;
   logic [1:0]      resp_last_q, resp_last_d;
   logic [1:0]      resp_idx_q, resp_idx_d;
   logic [TW-1:0]   tmr_q, tmr_d;

   tok_e tok;
   logic tok_hit, timed, tmo;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Anything that is not exactly one recognised hot bit is a FAIL token.
   always_comb begin
      tok = TokNone;
      if (UART_DEC_DVLD) begin
         case ({UART_DEC_STATE, UART_DEC_TEXT})
            6'b000_000:             tok = TokHex;
            6'b100_000:             tok = TokW;
            6'b010_000:             tok = TokR;
            6'b000_100:             tok = TokSp;
            6'b000_010, 6'b000_001: tok = TokEol;
            default:                tok = TokFail;
         endcase
      end
   end

   assign tok_hit = (tok != TokNone);
   assign timed   = state_q inside {StSep1, StAddr, StData, StFlush, StExecRd};
   assign tmo     = timed && (tmr_q == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d     = state_q;
      op_wr_d     = op_wr_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      resp_d      = resp_q;
      resp_last_d = resp_last_q;
      resp_idx_d  = resp_idx_q;
      tmr_d       = timed ? tmr_q + TW'(1) : '0;
      REG_WE      = 1'b0;
      REG_RE      = 1'b0;
      TX_DVLD     = 1'b0;
      TX_DATA     = 8'h00;
      TOK_DROP    = 1'b0;

      case (state_q)
         StIdle: begin
            if (tok == TokW || tok == TokR) begin
               state_d = StSep1;
               op_wr_d = (tok == TokW);
            end else if (tok == TokHex || tok == TokFail) begin
               state_d = StFlush;
            end
         end
         StSep1: begin
            if (tok_hit) begin
               if (tok == TokSp) begin
                  state_d = StAddr;
                  cnt_d   = '0;
               end else begin
                  state_d = (tok == TokEol) ? StErrResp : StFlush;
               end
            end else if (tmo) begin
               state_d = StErrResp;
            end
         end
         StAddr: begin
            if (tok_hit) begin
               if (cnt_q < CW'(ADDR_DIGITS)) begin
                  if (tok == TokHex) begin
                     addr_d = {addr_q[AW-5:0], UART_DEC_DATA};
                     cnt_d  = cnt_q + CW'(1);
                  end else begin
                     state_d = (tok == TokEol) ? StErrResp : StFlush;
                  end
               end else if (tok == TokSp && op_wr_q) begin
                  state_d = StData;
                  cnt_d   = '0;
               end else if (tok == TokEol && !op_wr_q) begin
                  state_d = StExecRd;
               end else begin
                  state_d = (tok == TokEol) ? StErrResp : StFlush;
               end
            end else if (tmo) begin
               state_d = StErrResp;
            end
         end
         StData: begin
            if (tok_hit) begin
               if (cnt_q < CW'(DATA_DIGITS)) begin
                  if (tok == TokHex) begin
                     data_d = {data_q[DW-5:0], UART_DEC_DATA};
                     cnt_d  = cnt_q + CW'(1);
                  end else begin
                     state_d = (tok == TokEol) ? StErrResp : StFlush;
                  end
               end else begin
                  state_d = (tok == TokEol) ? StExecWr : StFlush;
               end
            end else if (tmo) begin
               state_d = StErrResp;
            end
         end
         StExecWr: begin
            REG_WE      = 1'b1;
            resp_d      = {8'h00, 8'h0A, 8'h0D, 8'h4B};
            resp_last_d = 2'd2;
            resp_idx_d  = 2'd0;
            state_d     = StResp;
         end
         StExecRd: begin
            // Timer is cleared on entry, so tmr_q == 0 marks the strobe cycle.
            REG_RE   = (tmr_q == '0);
            TOK_DROP = tok_hit;
            if (tmr_q != '0 && REG_RVLD) begin
               resp_d      = {8'h0A, 8'h0D, hex_ascii(REG_RDATA[3:0]), hex_ascii(REG_RDATA[7:4])};
               resp_last_d = 2'd3;
               resp_idx_d  = 2'd0;
               state_d     = StResp;
            end else if (tmo) begin
               state_d = StErrResp;
            end
         end
         StFlush: begin
            if (tok == TokEol) begin
               state_d = StErrResp;
            end else if (!tok_hit && tmo) begin
               state_d = StErrResp;
            end
         end
         StErrResp: begin
            resp_d      = {8'h00, 8'h0A, 8'h0D, 8'h45};
            resp_last_d = 2'd2;
            resp_idx_d  = 2'd0;
            state_d     = StResp;
         end
         StResp: begin
            TX_DVLD  = 1'b1;
            TX_DATA  = resp_q[resp_idx_q];
            TOK_DROP = tok_hit;
            if (TX_RDY) begin
               if (resp_idx_q == resp_last_q) begin
                  state_d = StIdle;
               end else begin
                  resp_idx_d = resp_idx_q + 2'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q || (tok_hit && state_q != StExecRd)) begin
         tmr_d = '0;
      end
   end

   always_ff @(posedge CLK_100M or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         state_q     <= StIdle;
         op_wr_q     <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         resp_q      <= '0;
         resp_last_q <= 2'd0;
         resp_idx_q  <= 2'd0;
         tmr_q       <= '0;
      end else begin
         state_q     <= state_d;
         op_wr_q     <= op_wr_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         resp_q      <= resp_d;
         resp_last_q <= resp_last_d;
         resp_idx_q  <= resp_idx_d;
         tmr_q       <= tmr_d;
      end
   end

   assign REG_ADDR  = addr_q;
   assign REG_WDATA = data_q;
   assign CMD_BUSY  = (state_q != StIdle);

endmodule
